rx_frame_buffer: RTL and testbench
==================================

RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 SHALL have parameter MAC_ADDR, 48'h69_69_5A_06_54_91, station address matched against the destination field.
REQ-002 SHALL have parameter ACCEPT_BCAST, 1, when 1 destination FF:FF:FF:FF:FF:FF is also accepted.
REQ-003 SHALL have parameter ETYPE_EN, 0, when 1 the ethertype must equal ETYPE.
REQ-004 SHALL have parameter ETYPE, 16'h0800, required ethertype.
REQ-005 SHALL have parameter WORD_W, 32, output word width (even, 8..64).
REQ-006 SHALL have parameter MAX_WORDS, 1, payload words buffered per frame (1..8, with MAX_WORDS*WORD_W <= 368).
REQ-007 SHALL have parameter FCS_TIMEOUT, 16, cycles to wait for FCS status after the frame ends.
REQ-008 SHALL have parameter CNT_W, 14, counter width.
REQ-009 clk  in  1  single clock, all logic on posedge.
REQ-010 rst  in  1  asynchronous, active-high reset.
REQ-011 axiiv  in  1  dibit valid, high for the whole frame from destination through FCS.
REQ-012 axiid  in  2  dibit, byte-MSB-first order.
REQ-013 fcs_done  in  1  one-cycle pulse, FCS check finished.
REQ-014 fcs_kill  in  1  FCS bad, sampled only while fcs_done=1.
REQ-015 axior  in  1  downstream ready.
REQ-016 axiov  out  1  output word valid.
REQ-017 axiod  out  WORD_W  output word.
REQ-018 axiol  out  1  last word of the frame.
REQ-019 good_cnt  out  CNT_W  frames committed.
REQ-020 drop_cnt  out  CNT_W  frames rejected.

Function
REQ-021 SHALL implement states IDLE, HDR, PAYLOAD, WAIT_FCS, DRAIN, DROP.
REQ-022 SHALL keep an armed flag, cleared by reset and set whenever axiiv=0 is sampled; IDLE leaves to HDR only on axiiv=1 while armed, so a frame in progress at reset release is ignored.
REQ-023 HDR SHALL count 56 dibits: 0-23 destination, 24-47 source, 48-55 ethertype; the first dibit is MAC_ADDR[47:46].
REQ-024 On a destination mismatch, or an ethertype mismatch with ETYPE_EN=1, the block SHALL go to DROP at the end of dibit 55 and increment drop_cnt once.
REQ-025 PAYLOAD SHALL shift dibits into a word with the first dibit at [WORD_W-1:WORD_W-2]; each complete word is stored in the buffer until MAX_WORDS are held, after which later dibits are ignored.
REQ-026 On the axiiv 1->0 edge, HDR SHALL go to DROP (runt, drop_cnt+1), PAYLOAD SHALL go to WAIT_FCS, and any partial word SHALL be discarded.
REQ-027 In WAIT_FCS, fcs_done=1 with fcs_kill=0 SHALL increment good_cnt; the next state is DRAIN if the buffer holds 1 or more words, else IDLE.
REQ-028 In WAIT_FCS, fcs_kill=1, FCS_TIMEOUT cycles without fcs_done, or axiiv=1 SHALL discard the buffer, increment drop_cnt and go to DROP.
REQ-029 DRAIN SHALL raise axiov the cycle after commit, with axiod = word 0.
REQ-030 A word transfers when axiov&axior; axiod and axiol SHALL stay stable while axiov&!axior.
REQ-031 axiol SHALL be 1 only with the last stored word.
REQ-032 After the last transfer, axiov SHALL fall the next cycle; the state goes to DROP if axiiv=1, else IDLE.
REQ-033 A frame starting (armed, axiiv 0->1) during DRAIN SHALL be counted in drop_cnt once and not parsed.
REQ-034 DROP SHALL wait for axiiv=0, then go to IDLE.
REQ-035 fcs_done SHALL be ignored outside WAIT_FCS.
REQ-036 good_cnt and drop_cnt SHALL saturate at all-ones.

Reset
REQ-037 rst=1 SHALL immediately force: state IDLE, armed=0, axiov=0, axiod=0, axiol=0, good_cnt=0, drop_cnt=0, buffer marked empty.
REQ-038 An rst mid-frame or mid-drain SHALL abandon the frame without any count.

Verification
REQ-039 Frame to MAC_ADDR with payload DE AD BE EF..., fcs_done with fcs_kill=0, axior=1 -> one word axiod=32'hDEADBEEF, axiol=1, good_cnt=1.
REQ-040 Same frame to 02:00:00:00:00:01 -> no axiov, drop_cnt=1; with the broadcast destination and ACCEPT_BCAST=1 -> accepted.
REQ-041 Good frame with fcs_kill=1 -> no output, drop_cnt=1; no fcs_done within 16 cycles -> drop_cnt=1.
REQ-042 MAX_WORDS=3, WORD_W=16, axior low for 5 cycles during DRAIN -> words 0..2 in order, axiod held while stalled, axiol only on word 2; a second frame started in DRAIN -> drop_cnt=1.
REQ-043 rst released while axiiv=1 -> nothing parsed until axiiv low; a runt of 40 dibits -> drop_cnt=1; CNT_W=2 with 5 good frames -> good_cnt=3.

Source files
------------

// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: filters dibit Ethernet frames by destination/ethertype and releases payload words after a good FCS
module rx_frame_buffer #(
    parameter logic [47:0] MAC_ADDR     = 48'h69_69_5A_06_54_91,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter bit          ETYPE_EN     = 1'b0,
    parameter logic [15:0] ETYPE        = 16'h0800,
    parameter int          WORD_W       = 32,
    parameter int          MAX_WORDS    = 1,
    parameter int          FCS_TIMEOUT  = 16,
    parameter int          CNT_W        = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [1:0]        axiid,
    input  logic              fcs_done,
    input  logic              fcs_kill,
    input  logic              axior,
    output logic              axiov,
    output logic [WORD_W-1:0] axiod,
    output logic              axiol,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam logic [5:0]  DP_LAST = 6'(WORD_W / 2 - 1);
    localparam logic [3:0]  MW      = 4'(MAX_WORDS);
    localparam logic [15:0] TO_LAST = 16'(FCS_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, WAIT_FCS, DRAIN, DROP} state_t;

    state_t            r_state, w_state_n;
    logic              r_armed, r_iv_q;
    logic [5:0]        r_hcnt, r_dcnt;
    logic              r_mac_ok, r_bc_ok, r_et_ok;
    logic [WORD_W-3:0] r_sh;
    logic [WORD_W-1:0] r_buf [8];
    logic [3:0]        r_nw;
    logic [2:0]        r_rd;
    logic [15:0]       r_to;
    logic [5:0]        w_idx;
    logic [1:0]        w_mac_d, w_et_d;
    logic              w_first, w_mac_hit, w_bc_hit, w_et_hit, w_hdr_pass;
    logic              w_good_inc, w_drop_inc, w_xfer, w_last, w_store;
    logic [WORD_W-1:0] w_word;

    // The first destination dibit is consumed on the IDLE->HDR cycle, so IDLE compares at index 0
    assign w_idx      = (r_state == HDR) ? r_hcnt : 6'd0;
    assign w_first    = (r_state != HDR);
    assign w_mac_d    = 2'(MAC_ADDR >> {6'd23 - w_idx, 1'b0});
    assign w_et_d     = 2'(ETYPE >> {6'd55 - w_idx, 1'b0});
    assign w_mac_hit  = (w_first | r_mac_ok) & ((w_idx > 6'd23) | (axiid == w_mac_d));
    assign w_bc_hit   = (w_first | r_bc_ok) & ((w_idx > 6'd23) | (axiid == 2'b11));
    assign w_et_hit   = (w_first | r_et_ok) & ((w_idx < 6'd48) | (axiid == w_et_d));
    assign w_hdr_pass = (w_mac_hit | (ACCEPT_BCAST & w_bc_hit)) & (!ETYPE_EN | w_et_hit);

    assign w_word  = {r_sh, axiid};
    assign w_store = (r_state == PAYLOAD) & axiiv & (r_dcnt == DP_LAST) & (r_nw < MW);
    assign w_last  = ({1'b0, r_rd} == r_nw - 4'd1);
    assign axiov   = (r_state == DRAIN);
    assign axiod   = axiov ? r_buf[r_rd] : '0;
    assign axiol   = axiov & w_last;
    assign w_xfer  = axiov & axior;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_state_n;
    end

    // Next state and count strobes
    always_comb begin
        w_state_n  = r_state;
        w_good_inc = 1'b0;
        w_drop_inc = 1'b0;
        case (r_state)
            IDLE: if (axiiv && r_armed) w_state_n = HDR;
            HDR: begin
                if (!axiiv) begin
                    w_state_n  = DROP;
                    w_drop_inc = 1'b1;
                end else if (r_hcnt == 6'd55) begin
                    w_state_n  = w_hdr_pass ? PAYLOAD : DROP;
                    w_drop_inc = !w_hdr_pass;
                end
            end
            PAYLOAD: if (!axiiv) w_state_n = WAIT_FCS;
            WAIT_FCS: begin
                if (axiiv || (fcs_done && fcs_kill) || (!fcs_done && r_to == TO_LAST)) begin
                    w_state_n  = DROP;
                    w_drop_inc = 1'b1;
                end else if (fcs_done) begin
                    w_state_n  = (r_nw != 4'd0) ? DRAIN : IDLE;
                    w_good_inc = 1'b1;
                end
            end
            DRAIN: begin
                w_drop_inc = axiiv & !r_iv_q & r_armed;
                if (w_xfer && w_last) w_state_n = axiiv ? DROP : IDLE;
            end
            DROP: if (!axiiv) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Header match flags, payload word assembly, buffer occupancy and FCS wait timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed  <= 1'b0;
            r_iv_q   <= 1'b0;
            r_hcnt   <= 6'd0;
            r_mac_ok <= 1'b0;
            r_bc_ok  <= 1'b0;
            r_et_ok  <= 1'b0;
            r_dcnt   <= 6'd0;
            r_sh     <= '0;
            r_nw     <= 4'd0;
            r_rd     <= 3'd0;
            r_to     <= 16'd0;
        end else begin
            r_armed <= r_armed | !axiiv;
            r_iv_q  <= axiiv;
            if (r_state == IDLE || r_state == HDR) begin
                r_hcnt   <= w_idx + 6'd1;
                r_mac_ok <= w_mac_hit;
                r_bc_ok  <= w_bc_hit;
                r_et_ok  <= w_et_hit;
            end
            if (r_state == PAYLOAD && axiiv) r_sh <= w_word[WORD_W-3:0];
            r_dcnt <= (r_state == PAYLOAD && axiiv && r_dcnt != DP_LAST) ? r_dcnt + 6'd1 : 6'd0;
            r_to   <= (r_state == WAIT_FCS) ? r_to + 16'd1 : 16'd0;
            if (w_store) r_nw <= r_nw + 4'd1;
            if (w_state_n == IDLE || w_state_n == DROP) r_nw <= 4'd0;
            if (w_xfer) r_rd <= w_last ? 3'd0 : r_rd + 3'd1;
        end
    end

    // Payload word storage; occupancy is tracked by r_nw so the data itself needs no reset
    always_ff @(posedge clk) begin
        if (w_store) r_buf[r_nw[2:0]] <= w_word;
    end

    // Saturating frame counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (w_good_inc && !(&good_cnt)) good_cnt <= good_cnt + 1'b1;
            if (w_drop_inc && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rx_frame_buffer.sv
// tb_rx_frame_buffer: directed frames into a 32-bit/1-word and a 16-bit/3-word buffer with a word scoreboard
module tb_rx_frame_buffer;
    localparam logic [47:0] MAC   = 48'h69_69_5A_06_54_91;
    localparam logic [47:0] SRC   = 48'h02_11_22_33_44_55;
    localparam logic [15:0] ET    = 16'h0800;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0, rst = 1'b1, axiiv = 1'b0, fcs_done = 1'b0, fcs_kill = 1'b0, axior = 1'b1;
    logic [1:0]  axiid = 2'b00;
    logic        a_ov, a_ol, b_ov, b_ol;
    logic [31:0] a_od;
    logic [15:0] b_od;
    logic [13:0] a_good, a_drop;
    logic [1:0]  b_good, b_drop;

    int errors = 0, checks = 0, eg = 0, ed = 0;
    logic [7:0]  body [$];
    logic [32:0] qa [$];
    logic [16:0] qb [$];
    logic        a_stall = 1'b0, b_stall = 1'b0, a_fin = 1'b0, b_fin = 1'b0;
    logic [33:0] a_hold = '0;
    logic [17:0] b_hold = '0;

    rx_frame_buffer dut_a (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .fcs_done(fcs_done), .fcs_kill(fcs_kill),
        .axior(axior), .axiov(a_ov), .axiod(a_od), .axiol(a_ol), .good_cnt(a_good), .drop_cnt(a_drop)
    );

    rx_frame_buffer #(.WORD_W(16), .MAX_WORDS(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .fcs_done(fcs_done), .fcs_kill(fcs_kill),
        .axior(axior), .axiov(b_ov), .axiod(b_od), .axiol(b_ol), .good_cnt(b_good), .drop_cnt(b_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Output monitor: pops expected words on each transfer, checks hold under stall and valid fall after last
    always @(negedge clk) begin
        if (rst) begin
            a_stall = 1'b0; b_stall = 1'b0; a_fin = 1'b0; b_fin = 1'b0;
        end else begin
            if (a_stall) chk("a_hold", {a_ov, a_ol, a_od}, a_hold);
            if (b_stall) chk("b_hold", {b_ov, b_ol, b_od}, b_hold);
            if (a_fin) chk("a_ov_fall", a_ov, 1'b0);
            if (b_fin) chk("b_ov_fall", b_ov, 1'b0);
            a_stall = a_ov && !axior; a_hold = {a_ov, a_ol, a_od}; a_fin = a_ov && axior && a_ol;
            b_stall = b_ov && !axior; b_hold = {b_ov, b_ol, b_od}; b_fin = b_ov && axior && b_ol;
            if (a_ov && axior) begin
                if (qa.size() == 0) chk("a_spurious_ov", a_ov, 1'b0);
                else chk("a_word", {a_ol, a_od}, qa.pop_front());
            end
            if (b_ov && axior) begin
                if (qb.size() == 0) chk("b_spurious_ov", b_ov, 1'b0);
                else chk("b_word", {b_ol, b_od}, qb.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_field(input logic [47:0] v, input int nd);
        for (int i = nd - 1; i >= 0; i--) begin
            axiiv = 1'b1;
            axiid = v[2*i +: 2];
            tick();
        end
    endtask

    task automatic set_body(input int n);
        logic [31:0] lead = 32'hDEADBEEF;
        body.delete();
        for (int i = 0; i < n; i++) body.push_back(i < 4 ? lead[31-8*i -: 8] : 8'(i * 29 + 7));
    endtask

    task automatic push_expect;
        int k = (body.size() / 2 > 3) ? 3 : body.size() / 2;
        if (body.size() >= 4) qa.push_back({1'b1, body[0], body[1], body[2], body[3]});
        for (int j = 0; j < k; j++) qb.push_back({j == k - 1, body[2*j], body[2*j+1]});
    endtask

    task automatic send_frame(input logic [47:0] dst);
        send_field(dst, 24);
        send_field(SRC, 24);
        send_field({32'd0, ET}, 8);
        foreach (body[i]) send_field({40'd0, body[i]}, 4);
    endtask

    task automatic end_frame;
        axiiv = 1'b0;
        axiid = 2'b00;
        tick();
    endtask

    task automatic fcs(input logic kill);
        tick();
        tick();
        fcs_done = 1'b1;
        fcs_kill = kill;
        tick();
        fcs_done = 1'b0;
        fcs_kill = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && (qa.size() + qb.size()) != 0; i++) tick();
        chk({tag, "_drained"}, 64'(qa.size() + qb.size()), 64'd0);
        repeat (3) tick();
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_a_good"}, 64'(a_good), 64'(eg));
        chk({tag, "_a_drop"}, 64'(a_drop), 64'(ed));
        chk({tag, "_b_good"}, 64'(b_good), 64'(eg > 3 ? 3 : eg));
        chk({tag, "_b_drop"}, 64'(b_drop), 64'(ed > 3 ? 3 : ed));
    endtask

    task automatic good_frame(input logic [47:0] dst);
        set_body(12);
        push_expect();
        send_frame(dst);
        end_frame();
        fcs(1'b0);
        eg++;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_a_ov", a_ov, 1'b0);
        chk("rst_a_od", a_od, 32'd0);
        chk("rst_a_ol", a_ol, 1'b0);
        chk("rst_b_ov", b_ov, 1'b0);
        chk("rst_b_od", b_od, 16'd0);
        chk("rst_b_ol", b_ol, 1'b0);
        chk_cnts("rst");

        // reset released in the middle of valid data: the whole frame must be ignored
        rst = 1'b0;
        set_body(12);
        send_frame(MAC);
        end_frame();
        fcs(1'b0);
        wait_drain("armed");
        chk_cnts("armed");

        // station address, good FCS
        good_frame(MAC);
        chk("commit_a_ov", a_ov, 1'b1);
        chk("commit_a_od", a_od, 32'hDEADBEEF);
        wait_drain("good");
        chk_cnts("good");

        // foreign destination, FCS pulse afterwards is ignored
        set_body(12);
        send_frame(OTHER);
        end_frame();
        fcs(1'b0);
        ed++;
        wait_drain("foreign");
        chk_cnts("foreign");

        // broadcast destination
        good_frame(BCAST);
        wait_drain("bcast");
        chk_cnts("bcast");

        // bad FCS
        set_body(12);
        send_frame(MAC);
        end_frame();
        fcs(1'b1);
        ed++;
        wait_drain("kill");
        chk_cnts("kill");

        // no FCS status within the timeout, late pulse ignored
        set_body(12);
        send_frame(MAC);
        end_frame();
        repeat (20) tick();
        ed++;
        fcs(1'b0);
        wait_drain("timeout");
        chk_cnts("timeout");

        // stalled drain with a second frame arriving during the drain
        good_frame(MAC);
        axior = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 80; i++) begin
            axior = (i >= 3);
            axiiv = 1'b1;
            axiid = 2'b01;
            tick();
        end
        ed++;
        end_frame();
        wait_drain("stall");
        chk_cnts("stall");

        // runt: 40 dibits then line idle
        send_field(MAC, 24);
        send_field(SRC, 16);
        end_frame();
        ed++;
        tick();
        chk_cnts("runt");

        // reset during drain abandons the frame at once
        good_frame(MAC);
        rst = 1'b1;
        #1;
        chk("rstdrain_a_ov", a_ov, 1'b0);
        chk("rstdrain_b_ov", b_ov, 1'b0);
        qa.delete();
        qb.delete();
        eg = 0;
        ed = 0;
        chk_cnts("rstdrain");
        tick();
        rst = 1'b0;
        tick();

        // five good frames saturate the 2-bit counter
        for (int n = 0; n < 5; n++) begin
            good_frame(MAC);
            wait_drain("sat");
        end
        chk_cnts("sat");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
